// File: rtl/rll_pkg.sv
// rtl/rll_pkg.sv - shared types and helpers for the keyed XOR/XNOR lock stage
package rll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } rll_state_e;

  // Number of key-load chunks that make up one full key.
  function automatic int num_chunks(input int num_keys, input int chunk_w);
    return num_keys / chunk_w;
  endfunction

  // Counter width able to index every chunk; never narrower than one bit.
  function automatic int cnt_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/rll_key_loader.sv
// rtl/rll_key_loader.sv - atomic serial key loader with malformed-load detection
module rll_key_loader
  import rll_pkg::*;
#(
  parameter int NUM_KEYS = 32,
  parameter int CHUNK_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [CHUNK_W-1:0]  key_data,
  input  logic                key_last,
  input  logic                key_clear,
  output logic [NUM_KEYS-1:0] applied_key,
  output logic                key_loaded,
  output logic                key_err
);

  localparam int NCH   = num_chunks(NUM_KEYS, CHUNK_W);
  localparam int CNT_W = cnt_width(NCH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  if ((CHUNK_W < 1) || (NUM_KEYS % CHUNK_W != 0)) begin : g_bad_chunk_w
    $error("rll_key_loader: NUM_KEYS must be a non-zero multiple of CHUNK_W");
  end

  rll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] shadow_q, shadow_d;
  logic [NUM_KEYS-1:0] applied_q, applied_d;
  logic                loaded_q, loaded_d;
  logic                err_q, err_d;

  logic                accept;
  logic                is_final;
  logic [NUM_KEYS-1:0] shadow_merged;

  // A clear in the same cycle refuses the chunk, so it also drops ready.
  assign key_ready = (state_q != ST_ARMED) && !key_clear;
  assign accept    = key_valid && key_ready;
  assign is_final  = (cnt_q == LAST_CNT);

  // Shadow key with the incoming chunk dropped into its slot, used to commit atomically.
  always_comb begin
    shadow_merged = shadow_q;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        shadow_merged[k*CHUNK_W +: CHUNK_W] = key_data;
      end
    end
  end

  // Load FSM: collect chunks, commit on a well-formed final chunk, flag anything else.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    applied_d = applied_q;
    loaded_d  = loaded_q;
    err_d     = err_q;
    if (key_clear) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      shadow_d  = '0;
      applied_d = '0;
      loaded_d  = 1'b0;
      err_d     = 1'b0;
    end else if (accept) begin
      if (is_final && key_last) begin
        applied_d = shadow_merged;
        shadow_d  = shadow_merged;
        loaded_d  = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ARMED;
      end else if (is_final || key_last) begin
        // Applied key and loaded flag survive a malformed load untouched.
        err_d    = 1'b1;
        shadow_d = '0;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end else begin
        shadow_d = shadow_merged;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = ST_LOAD;
      end
    end
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      applied_q <= '0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      applied_q <= applied_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
    end
  end

  assign applied_key = applied_q;
  assign key_loaded  = loaded_q;
  assign key_err     = err_q;

endmodule

// File: rtl/rll_keyed_stage.sv
// rtl/rll_keyed_stage.sv - keyed XOR/XNOR gate array with serial key register and data pipeline
module rll_keyed_stage
  import rll_pkg::*;
#(
  parameter int                 NUM_KEYS     = 32,
  parameter int                 CHUNK_W      = 8,
  parameter logic [NUM_KEYS-1:0] KEY_POLARITY = 32'hA5A5_0F0F,
  parameter int                 PIPE_STAGES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [CHUNK_W-1:0]  key_data,
  input  logic                key_last,
  input  logic                key_clear,
  input  logic                in_valid,
  input  logic [NUM_KEYS-1:0] wire_in,
  output logic                out_valid,
  output logic [NUM_KEYS-1:0] out_wire,
  output logic                key_loaded,
  output logic                key_err
);

  if ((PIPE_STAGES < 0) || (PIPE_STAGES > 2)) begin : g_bad_pipe
    $error("rll_keyed_stage: PIPE_STAGES must be 0, 1 or 2");
  end

  logic [NUM_KEYS-1:0] applied_key;
  logic [NUM_KEYS-1:0] keyed;

  rll_key_loader #(
    .NUM_KEYS (NUM_KEYS),
    .CHUNK_W  (CHUNK_W)
  ) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_data    (key_data),
    .key_last    (key_last),
    .key_clear   (key_clear),
    .applied_key (applied_key),
    .key_loaded  (key_loaded),
    .key_err     (key_err)
  );

  // XNOR gates are XOR gates with the polarity bit folded in; the right key cancels it.
  assign keyed = wire_in ^ applied_key ^ KEY_POLARITY;

  if (PIPE_STAGES == 0) begin : g_comb
    assign out_wire  = keyed;
    assign out_valid = in_valid;
  end else begin : g_pipe
    logic [PIPE_STAGES-1:0][NUM_KEYS-1:0] data_q;
    logic [PIPE_STAGES-1:0]               valid_q;

    // Free-running register chain; the valid bit travels alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q[0]  <= keyed;
        valid_q[0] <= in_valid;
        for (int s = 1; s < PIPE_STAGES; s++) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
      end
    end

    assign out_wire  = data_q[PIPE_STAGES-1];
    assign out_valid = valid_q[PIPE_STAGES-1];
  end

endmodule

// File: tb/tb_rll_keyed_stage.sv
// tb/tb_rll_keyed_stage.sv - bench for rll_keyed_stage at pipeline depths 0, 1 and 2
module tb_rll_keyed_stage;

  localparam logic [31:0] POL = 32'hA5A5_0F0F;

  typedef struct {
    logic        kv;
    logic [7:0]  kd;
    logic        kl;
    logic        kc;
    logic        iv;
    logic [31:0] wi;
    logic        el;
    logic        ee;
    logic        er;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid, key_last, key_clear, in_valid;
  logic [7:0]  key_data;
  logic [31:0] wire_in;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, ld0, ld1, ld2, er0, er1, er2;
  logic [31:0] ow0, ow1, ow2;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  logic [31:0] mkey, msh;
  int          mcnt;
  logic        mloaded, merr, marmed;

  exp_t        q1[$];
  exp_t        q2[$];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  rll_keyed_stage #(.NUM_KEYS(32), .CHUNK_W(8), .KEY_POLARITY(POL), .PIPE_STAGES(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(rdy0), .key_data(key_data),
    .key_last(key_last), .key_clear(key_clear), .in_valid(in_valid), .wire_in(wire_in),
    .out_valid(ov0), .out_wire(ow0), .key_loaded(ld0), .key_err(er0));

  rll_keyed_stage #(.NUM_KEYS(32), .CHUNK_W(8), .KEY_POLARITY(POL), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(rdy1), .key_data(key_data),
    .key_last(key_last), .key_clear(key_clear), .in_valid(in_valid), .wire_in(wire_in),
    .out_valid(ov1), .out_wire(ow1), .key_loaded(ld1), .key_err(er1));

  rll_keyed_stage #(.NUM_KEYS(32), .CHUNK_W(8), .KEY_POLARITY(POL), .PIPE_STAGES(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(rdy2), .key_data(key_data),
    .key_last(key_last), .key_clear(key_clear), .in_valid(in_valid), .wire_in(wire_in),
    .out_valid(ov2), .out_wire(ow2), .key_loaded(ld2), .key_err(er2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic kv, input logic [7:0] kd, input logic kl, input logic kc,
                       input logic iv, input logic [31:0] wi);
    key_valid = kv;
    key_data  = kd;
    key_last  = kl;
    key_clear = kc;
    in_valid  = iv;
    wire_in   = wi;
  endtask

  function automatic vec_t mk(input logic kv, input logic [7:0] kd, input logic kl, input logic kc,
                              input logic iv, input logic [31:0] wi,
                              input logic el, input logic ee, input logic er);
    vec_t v;
    v.kv = kv; v.kd = kd; v.kl = kl; v.kc = kc; v.iv = iv; v.wi = wi;
    v.el = el; v.ee = ee; v.er = er;
    return v;
  endfunction

  task automatic model_reset();
    mkey = '0; msh = '0; mcnt = 0; mloaded = 1'b0; merr = 1'b0; marmed = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  task automatic model_edge();
    if (key_clear) begin
      mkey = '0; msh = '0; mcnt = 0; mloaded = 1'b0; merr = 1'b0; marmed = 1'b0;
    end else if (key_valid && !marmed) begin
      msh[mcnt*8 +: 8] = key_data;
      if (mcnt == 3 && key_last) begin
        mkey = msh; mloaded = 1'b1; marmed = 1'b1; mcnt = 0;
      end else if (mcnt == 3 || key_last) begin
        merr = 1'b1; msh = '0; mcnt = 0;
      end else begin
        mcnt++;
      end
    end
  endtask

  task automatic chk_pipe(input int p, input logic ov, input logic [31:0] ow);
    exp_t e;
    int   n;
    n = (p == 1) ? q1.size() : q2.size();
    if (n > 0) e = (p == 1) ? q1[0] : q2[0];
    if (ov) begin
      if (n == 0) begin
        chk($sformatf("p%0d_spurious_valid", p), 32'(ov), 32'd0);
      end else begin
        if (p == 1) void'(q1.pop_front()); else void'(q2.pop_front());
        chk($sformatf("p%0d_data", p), ow, e.data);
        chk($sformatf("p%0d_latency_due", p), 32'(cyc), 32'(e.due));
      end
    end else if (n > 0 && e.due <= cyc) begin
      if (p == 1) void'(q1.pop_front()); else void'(q2.pop_front());
      chk($sformatf("p%0d_missing_valid", p), 32'(ov), 32'd1);
    end
  endtask

  // One clock: check combinational depth-0 output, queue pipelined expectations, step model.
  task automatic cycle();
    logic [31:0] e;
    exp_t        x;
    #1;
    e = wire_in ^ mkey ^ POL;
    chk("p0_valid", 32'(ov0), 32'(in_valid));
    if (in_valid) begin
      chk("p0_data", ow0, e);
      x.data = e;
      x.due = cyc + 1; q1.push_back(x);
      x.due = cyc + 2; q2.push_back(x);
    end
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("key_ready", 32'(rdy1), 32'(!marmed && !key_clear));
    chk("key_loaded", 32'(ld1), 32'(mloaded));
    chk("key_err", 32'(er1), 32'(merr));
    chk("p0p2_flags", {29'd0, ld0 ^ ld2, er0 ^ er2, rdy0 ^ rdy2}, {29'd0, 3'b000});
    chk_pipe(1, ov1, ow1);
    chk_pipe(2, ov2, ow2);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    model_reset();
    chk("rst_out_wire_p1", ow1, 32'h0);
    chk("rst_out_wire_p2", ow2, 32'h0);
    chk("rst_out_valid", {30'd0, ov1, ov2}, 32'd0);
    chk("rst_key_ready", 32'(rdy1), 32'd1);
    chk("rst_key_loaded", 32'(ld1), 32'd0);
    chk("rst_key_err", 32'(er1), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_key(input logic [31:0] k);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, k[i*8 +: 8], (i == 3), 1'b0, 1'b0, 32'h0);
      cycle();
    end
  endtask

  initial begin
    // Scenario 2-4 vectors: inputs, then loaded/err/ready expected after the edge.
    tbl.push_back(mk(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 32'h89AB_CDEF, 1'b1, 1'b0, 1'b0));

    apply_reset();

    // Scenario 1: no key applied, zero input shows raw polarity after one clock.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
    cycle();
    chk("s1_out_wire", ow1, POL);
    chk("s1_out_valid", 32'(ov1), 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].kv, tbl[i].kd, tbl[i].kl, tbl[i].kc, tbl[i].iv, tbl[i].wi);
      cycle();
      chk($sformatf("tbl%0d_loaded", i), 32'(ld1), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_err", i), 32'(er1), 32'(tbl[i].ee));
      chk($sformatf("tbl%0d_ready", i), 32'(rdy1), 32'(tbl[i].er));
    end

    // Correct key armed: identity transfer with latency 0, 1 and 2.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    #1;
    chk("s6_p0_identity", ow0, 32'h1234_5678);
    cycle();
    chk("s6_p1_identity", ow1, 32'h1234_5678);
    chk("s6_p2_not_yet", 32'(ov2), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("s6_p2_identity", ow2, 32'h1234_5678);
    chk("s6_p2_valid", 32'(ov2), 32'd1);

    // Scenario 4 hand check: clear with a same-cycle chunk leaves raw polarity.
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
    cycle();
    chk("s4_out_after_clear", ow1, POL);
    chk("s4_ready_idle", 32'(rdy1), 32'd1);

    // Scenario 5: reset in the middle of a load and of a valid stream.
    drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 32'h0F0F_0F0F);
    cycle();
    drive(1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0);
    cycle();
    apply_reset();
    load_key(32'hFFFF_FFFF);
    chk("s5_loaded", 32'(ld1), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
    cycle();
    chk("s5_out_wire", ow1, 32'h5A5A_F0F0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
